// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: state and shift-type enums, datapath width.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SHT_SLL,
    SHT_SRL,
    SHT_SRA
  } shift_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ALU function (add/sub/logic/compare/LUI) plus illegal-code flag.
// Shift codes are recognised here but their result is produced by the caller.
`ifndef ALU_DEFS_SV
`include "alu_defs.sv"
`endif

module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned CTL_WIDTH = `ALU_CTL_WIDTH
) (
  input  logic [CTL_WIDTH-1:0] ctl,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  output logic [XLEN-1:0]      result,
  output logic                 illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (ctl)
      `ALU_ADD:  result = a + b;
      `ALU_SUB:  result = a - b;
      `ALU_XOR:  result = a ^ b;
      `ALU_OR:   result = a | b;
      `ALU_AND:  result = a & b;
      `ALU_LUI:  result = b;
      `ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) <  $signed(b)};
      `ALU_SGE:  result = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
      `ALU_SLTU: result = {{(XLEN-1){1'b0}}, a <  b};
      `ALU_SGEU: result = {{(XLEN-1){1'b0}}, a >= b};
      `ALU_SEQ:  result = {{(XLEN-1){1'b0}}, a == b};
      `ALU_SNE:  result = {{(XLEN-1){1'b0}}, a != b};
      `ALU_SLL, `ALU_SRL, `ALU_SRA: result = '0;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_defs.sv
// ALU control code encodings shared by the decoder and the execute stages.
`ifndef ALU_DEFS_SV
`define ALU_DEFS_SV

`define ALU_CTL_WIDTH 4

`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_LUI  4'd10
`define ALU_SEQ  4'd11
`define ALU_SNE  4'd12
`define ALU_SGE  4'd13
`define ALU_SGEU 4'd14

`endif

// File: rtl/alu_exec_stage.sv
// Registered single-entry ALU execute stage with valid/ready on both sides.
// Shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN selects a barrel shifter.
`ifndef ALU_DEFS_SV
`include "alu_defs.sv"
`endif

module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = alu_pkg::XLEN,
  parameter int unsigned CTL_WIDTH = `ALU_CTL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTL_WIDTH-1:0] in_ctl,
  input  logic [XLEN-1:0]      in_a,
  input  logic [XLEN-1:0]      in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic                 out_illegal
);

  state_e            state;
  logic [XLEN-1:0]   core_res;
  logic              core_ill;
  logic              is_shift;
  logic              accept;

  alu_comb_core #(.CTL_WIDTH(CTL_WIDTH)) u_core (
    .ctl     (in_ctl),
    .a       (in_a),
    .b       (in_b),
    .result  (core_res),
    .illegal (core_ill)
  );

  assign is_shift = (in_ctl == `ALU_SLL) || (in_ctl == `ALU_SRL) || (in_ctl == `ALU_SRA);
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] shift_res;

  always_comb begin
    shift_res = '0;
    case (in_ctl)
      `ALU_SLL: shift_res = in_a << in_b[SHAMT_W-1:0];
      `ALU_SRL: shift_res = in_a >> in_b[SHAMT_W-1:0];
      `ALU_SRA: shift_res = $signed(in_a) >>> in_b[SHAMT_W-1:0];
      default:  shift_res = '0;
    endcase
  end
`else
  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] cnt;
  shift_e             sh_type;
  shift_e             sh_sel;
  logic [XLEN-1:0]    step_res;

  always_comb begin
    sh_sel = SHT_SLL;
    if (in_ctl == `ALU_SRL) sh_sel = SHT_SRL;
    if (in_ctl == `ALU_SRA) sh_sel = SHT_SRA;
  end

  always_comb begin
    step_res = '0;
    case (sh_type)
      SHT_SLL: step_res = {acc[XLEN-2:0], 1'b0};
      SHT_SRL: step_res = {1'b0, acc[XLEN-1:1]};
      SHT_SRA: step_res = {acc[XLEN-1], acc[XLEN-1:1]};
      default: step_res = acc;
    endcase
  end
`endif

  // Accept is checked before DONE-drain so a completing result and a new op share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      acc         <= '0;
      cnt         <= '0;
      sh_type     <= SHT_SLL;
`endif
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt       <= '0;
`endif
    end else if (accept) begin
      if (is_shift) begin
`ifdef ALU_FAST_SHIFT_EN
        out_result  <= shift_res;
        out_illegal <= 1'b0;
        out_valid   <= 1'b1;
        state       <= DONE;
`else
        acc         <= in_a;
        cnt         <= in_b[SHAMT_W-1:0];
        sh_type     <= sh_sel;
        out_illegal <= 1'b0;
        if (in_b[SHAMT_W-1:0] == '0) begin
          out_result <= in_a;
          out_valid  <= 1'b1;
          state      <= DONE;
        end else begin
          out_valid  <= 1'b0;
          state      <= SHIFT;
        end
`endif
      end else begin
        out_result  <= core_res;
        out_illegal <= core_ill;
        out_valid   <= 1'b1;
        state       <= DONE;
      end
    end else if ((state == DONE) && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
`ifndef ALU_FAST_SHIFT_EN
    else if (state == SHIFT) begin
      acc <= step_res;
      cnt <= cnt - 1'b1;
      if (cnt == SHAMT_W'(1)) begin
        out_result <= step_res;
        out_valid  <= 1'b1;
        state      <= DONE;
      end
    end
`endif
  end

endmodule
